// File: rtl/mmse_2.sv
// 2x2 complex MIMO MMSE detector on the real 4x4 form: X = (H'H + N)^-1 * H'Y in Q8.8.
// One MAC per cycle builds [A | B], then unpivoted Gauss-Jordan leaves X in the B columns.
module mmse_2 #(
  parameter int unsigned W    = 16,
  parameter int unsigned FRAC = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [W-1:0] h11, h12, h13, h14, h21, h22, h23, h24,
  input  logic [W-1:0] h31, h32, h33, h34, h41, h42, h43, h44,
  input  logic [W-1:0] y11, y12, y21, y22, y31, y32, y41, y42,
  input  logic [W-1:0] n11, n12, n13, n14, n21, n22, n23, n24,
  input  logic [W-1:0] n31, n32, n33, n34, n41, n42, n43, n44,
  output logic [W-1:0] x11, x12, x21, x22, x31, x32, x41, x42,
  output logic         finish
);
  localparam int unsigned AccW = 2 * W;
  localparam logic signed [AccW-1:0] SatMax = AccW'((1 << (W - 1)) - 1);
  localparam logic signed [AccW-1:0] SatMin = -SatMax - 1;

  typedef enum logic [2:0] {StIdle, StLoad, StGram, StElim, StDone} state_e;

  function automatic logic signed [AccW-1:0] sx(input logic [W-1:0] a);
    return $signed({{(AccW - W){a[W-1]}}, a});
  endfunction

  function automatic logic [W-1:0] sat(input logic signed [AccW-1:0] v);
    if (v > SatMax) return SatMax[W-1:0];
    else if (v < SatMin) return SatMin[W-1:0];
    else return v[W-1:0];
  endfunction

  state_e state_q, state_d;
  logic [W-1:0] h_in [4][4];
  logic [W-1:0] y_in [4][2];
  logic [W-1:0] n_in [4][4];
  logic [W-1:0] h_q [4][4];
  logic [W-1:0] y_q [4][2];
  logic [W-1:0] n_q [4][4];
  logic [W-1:0] m_q [4][6];
  logic [W-1:0] x_q [4][2];
  logic [W-1:0] f_q;
  logic signed [AccW-1:0] acc_q;
  logic [4:0] ent_q;
  logic [1:0] kk_q, piv_q, rw_q;
  logic [2:0] sc_q;
  logic       tail_q;

  assign h_in = '{'{h11, h12, h13, h14}, '{h21, h22, h23, h24},
                  '{h31, h32, h33, h34}, '{h41, h42, h43, h44}};
  assign y_in = '{'{y11, y12}, '{y21, y22}, '{y31, y32}, '{y41, y42}};
  assign n_in = '{'{n11, n12, n13, n14}, '{n21, n22, n23, n24},
                  '{n31, n32, n33, n34}, '{n41, n42, n43, n44}};

  // Gram entry: 0..15 are A[r][c], 16..23 are B[r][c] stored in columns 4..5.
  logic [1:0] g_row;
  logic [2:0] g_col;
  logic [W-1:0] g_b, g_base;
  logic signed [AccW-1:0] g_sum;

  always_comb begin
    g_row  = ent_q[3:2];
    g_col  = {1'b0, ent_q[1:0]};
    g_b    = h_q[kk_q][ent_q[1:0]];
    g_base = n_q[ent_q[3:2]][ent_q[1:0]];
    if (ent_q[4]) begin
      g_row  = ent_q[2:1];
      g_col  = {2'b10, ent_q[0]};
      g_b    = y_q[kk_q][ent_q[0]];
      g_base = '0;
    end
    g_sum = ((kk_q == 2'd0) ? sx(g_base) : acc_q)
          + ((sx(h_q[kk_q][g_row]) * sx(g_b)) >>> FRAC);
  end

  // rw_q == 0 scales the pivot row (pivot column last); rw_q 1..3 eliminates the other rows.
  logic [1:0] e_row, rw_m1;
  logic [2:0] e_col;
  logic [W-1:0] e_f, e_val;
  logic signed [AccW-1:0] e_num, e_quo;

  always_comb begin
    rw_m1 = rw_q - 2'd1;
    e_row = piv_q;
    e_col = sc_q;
    e_f   = f_q;
    e_num = '0;
    e_quo = '0;
    e_val = '0;
    if (rw_q == 2'd0) begin
      if (sc_q == 3'd5) e_col = {1'b0, piv_q};
      else if (sc_q < {1'b0, piv_q}) e_col = sc_q;
      else e_col = sc_q + 3'd1;
      e_num = sx(m_q[piv_q][e_col]) <<< FRAC;
      if (m_q[piv_q][piv_q] == '0) e_quo = e_num[AccW-1] ? SatMin : SatMax;
      else e_quo = e_num / sx(m_q[piv_q][piv_q]);
      e_val = sat(e_quo);
    end else begin
      e_row = (rw_m1 < piv_q) ? rw_m1 : rw_q;
      // Factor is taken before column piv_q of this row gets overwritten.
      if (sc_q == 3'd0) e_f = m_q[e_row][piv_q];
      e_val = sat(sx(m_q[e_row][e_col]) - ((sx(e_f) * sx(m_q[piv_q][e_col])) >>> FRAC));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StLoad;
      StLoad:  state_d = StGram;
      StGram:  if (ent_q == 5'd23 && kk_q == 2'd3) state_d = StElim;
      StElim:  if (tail_q) state_d = StDone;
      StDone:  if (!start) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_q    <= '{default: '0};
      y_q    <= '{default: '0};
      n_q    <= '{default: '0};
      m_q    <= '{default: '0};
      x_q    <= '{default: '0};
      f_q    <= '0;
      acc_q  <= '0;
      ent_q  <= '0;
      kk_q   <= '0;
      piv_q  <= '0;
      rw_q   <= '0;
      sc_q   <= '0;
      tail_q <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start) begin
            h_q <= h_in;
            y_q <= y_in;
            n_q <= n_in;
          end
        end
        StLoad: begin
          acc_q  <= '0;
          ent_q  <= '0;
          kk_q   <= '0;
          piv_q  <= '0;
          rw_q   <= '0;
          sc_q   <= '0;
          f_q    <= '0;
          tail_q <= 1'b0;
        end
        StGram: begin
          acc_q <= g_sum;
          kk_q  <= kk_q + 2'd1;
          if (kk_q == 2'd3) begin
            m_q[g_row][g_col] <= sat(g_sum);
            ent_q <= ent_q + 5'd1;
          end
        end
        StElim: begin
          if (tail_q) begin
            for (int r = 0; r < 4; r++) begin
              for (int c = 0; c < 2; c++) x_q[r][c] <= m_q[r][4+c];
            end
          end else begin
            m_q[e_row][e_col] <= e_val;
            f_q <= e_f;
            if (sc_q == 3'd5) begin
              sc_q <= '0;
              rw_q <= rw_q + 2'd1;
              if (rw_q == 2'd3) begin
                piv_q <= piv_q + 2'd1;
                if (piv_q == 2'd3) tail_q <= 1'b1;
              end
            end else begin
              sc_q <= sc_q + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign finish = (state_q == StDone);
  assign x11 = x_q[0][0];
  assign x12 = x_q[0][1];
  assign x21 = x_q[1][0];
  assign x22 = x_q[1][1];
  assign x31 = x_q[2][0];
  assign x32 = x_q[2][1];
  assign x41 = x_q[3][0];
  assign x42 = x_q[3][1];

endmodule

// File: tb/tb_mmse_2.sv
// Bench for mmse_2: directed and random solves against a loop-level fixed-point reference.
module tb_mmse_2;
  logic clk = 1'b0;
  logic reset;
  logic start;
  logic [15:0] h [4][4];
  logic [15:0] y [4][2];
  logic [15:0] n [4][4];
  logic [15:0] xo [4][2];
  logic finish;
  int exp_x [4][2];
  int vectors = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mmse_2 dut (
    .clk(clk), .reset(reset), .start(start),
    .h11(h[0][0]), .h12(h[0][1]), .h13(h[0][2]), .h14(h[0][3]),
    .h21(h[1][0]), .h22(h[1][1]), .h23(h[1][2]), .h24(h[1][3]),
    .h31(h[2][0]), .h32(h[2][1]), .h33(h[2][2]), .h34(h[2][3]),
    .h41(h[3][0]), .h42(h[3][1]), .h43(h[3][2]), .h44(h[3][3]),
    .y11(y[0][0]), .y12(y[0][1]), .y21(y[1][0]), .y22(y[1][1]),
    .y31(y[2][0]), .y32(y[2][1]), .y41(y[3][0]), .y42(y[3][1]),
    .n11(n[0][0]), .n12(n[0][1]), .n13(n[0][2]), .n14(n[0][3]),
    .n21(n[1][0]), .n22(n[1][1]), .n23(n[1][2]), .n24(n[1][3]),
    .n31(n[2][0]), .n32(n[2][1]), .n33(n[2][2]), .n34(n[2][3]),
    .n41(n[3][0]), .n42(n[3][1]), .n43(n[3][2]), .n44(n[3][3]),
    .x11(xo[0][0]), .x12(xo[0][1]), .x21(xo[1][0]), .x22(xo[1][1]),
    .x31(xo[2][0]), .x32(xo[2][1]), .x41(xo[3][0]), .x42(xo[3][1]),
    .finish(finish)
  );

  function automatic longint sat16(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic longint s16(logic [15:0] v);
    return longint'($signed(v));
  endfunction

  // Reference: build [A | B] with plain sums, then textbook Gauss-Jordan in the Q8.8 rules.
  task automatic model();
    longint m [4][6];
    longint acc, piv, f, b;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 6; c++) begin
        acc = (c < 4) ? s16(n[r][c % 4]) : 0;
        for (int k = 0; k < 4; k++) begin
          if (c < 4) b = s16(h[k][c]);
          else b = s16(y[k][c - 4]);
          acc += (s16(h[k][r]) * b) >>> 8;
        end
        m[r][c] = sat16(acc);
      end
    end
    for (int k = 0; k < 4; k++) begin
      piv = m[k][k];
      for (int j = 0; j < 6; j++) begin
        if (piv == 0) m[k][j] = (m[k][j] >= 0) ? 32767 : -32768;
        else m[k][j] = sat16((m[k][j] * 256) / piv);
      end
      for (int i = 0; i < 4; i++) begin
        if (i != k) begin
          f = m[i][k];
          for (int j = 0; j < 6; j++) m[i][j] = sat16(m[i][j] - ((f * m[k][j]) >>> 8));
        end
      end
    end
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 2; c++) exp_x[r][c] = int'(m[r][4+c]);
  endtask

  task automatic set_diag(input logic [15:0] hd, input logic [15:0] nd, input logic [15:0] yv);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        h[r][c] = (r == c) ? hd : 16'h0000;
        n[r][c] = (r == c) ? nd : 16'h0000;
      end
      y[r][0] = yv;
      y[r][1] = yv;
    end
  endtask

  task automatic scramble();
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        h[r][c] = 16'($urandom);
        n[r][c] = 16'($urandom);
      end
      y[r][0] = 16'($urandom);
      y[r][1] = 16'($urandom);
    end
  endtask

  task automatic check_x(input string name, input bit use_const, input int want);
    logic [15:0] w;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 2; c++) begin
        w = use_const ? want[15:0] : exp_x[r][c][15:0];
        vectors++;
        if (xo[r][c] !== w) begin
          errors++;
          $display("FAIL %s x%0d%0d: got %h want %h", name, r + 1, c + 1, xo[r][c], w);
        end
      end
    end
  endtask

  // Full transaction: latency, result, hold while start=1, drop to IDLE with outputs held.
  task automatic run_solve(input string name, input bit use_const, input int want);
    int cyc;
    model();
    if (use_const) begin
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 2; c++) begin
          vectors++;
          if (exp_x[r][c] !== want) begin
            errors++;
            $display("FAIL %s model x%0d%0d: got %0d want %0d", name, r + 1, c + 1,
                     exp_x[r][c], want);
          end
        end
    end
    start = 1'b1;
    @(posedge clk); #1;
    scramble();
    cyc = 0;
    while (!finish && cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 5) start = 1'b0;
      if (cyc == 20) start = 1'b1;
    end
    vectors++;
    if (cyc !== 194) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles want 194", name, cyc);
    end
    check_x(name, 1'b0, 0);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (finish !== 1'b1) begin
      errors++;
      $display("FAIL %s hold finish: got %b want 1", name, finish);
    end
    check_x({name, " hold"}, 1'b0, 0);
    start = 1'b0;
    @(posedge clk); #1;
    vectors++;
    if (finish !== 1'b0) begin
      errors++;
      $display("FAIL %s drop finish: got %b want 0", name, finish);
    end
    check_x({name, " idle"}, 1'b0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    set_diag(16'h0000, 16'h0000, 16'h0000);
    repeat (3) @(posedge clk);
    #1;
    vectors++;
    if (finish !== 1'b0) begin
      errors++;
      $display("FAIL reset finish: got %b want 0", finish);
    end
    check_x("reset", 1'b1, 0);
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_identity();
    set_diag(16'h0100, 16'h0000, 16'h0019);
    run_solve("identity", 1'b1, 32'h19);
  endtask

  task automatic test_scaled();
    set_diag(16'h0200, 16'h0000, 16'h0100);
    run_solve("scaled", 1'b1, 32'h80);
  endtask

  task automatic test_regularised();
    set_diag(16'h0100, 16'h0100, 16'h0100);
    run_solve("reg_n1", 1'b1, 32'h80);
    set_diag(16'h0100, 16'h0300, 16'h0100);
    run_solve("reg_n3", 1'b1, 32'h40);
  endtask

  task automatic test_mixed();
    h = '{'{16'h0100, 16'h0019, 16'h0033, 16'h0019}, '{16'h0019, 16'h0100, 16'h0019, 16'h0019},
          '{16'h0019, 16'h0019, 16'h0033, 16'h0100}, '{16'h0033, 16'h0019, 16'h0100, 16'h0019}};
    y = '{'{16'h0019, 16'h0019}, '{16'h0019, 16'h0019}, '{16'h0033, 16'h0019},
          '{16'h0019, 16'h0033}};
    n = '{'{16'h0033, 16'h0019, 16'h0000, 16'h0000}, '{16'h0019, 16'h0033, 16'h0000, 16'h0000},
          '{16'h0000, 16'h0000, 16'h0033, 16'h0019}, '{16'h0000, 16'h0000, 16'h0019, 16'h0033}};
    run_solve("mixed", 1'b0, 0);
  endtask

  task automatic test_mid_reset();
    set_diag(16'h0200, 16'h0100, 16'h0033);
    start = 1'b1;
    @(posedge clk); #1;
    repeat (51) @(posedge clk);
    #3;
    reset = 1'b0;
    start = 1'b0;
    #1;
    vectors++;
    if (finish !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset finish: got %b want 0", finish);
    end
    check_x("mid_reset", 1'b1, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run_solve("after_reset", 1'b0, 0);
  endtask

  task automatic test_zero();
    set_diag(16'h0000, 16'h0000, 16'h0000);
    run_solve("zero", 1'b0, 0);
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 2; c++) begin
        vectors++;
        if ($isunknown(xo[r][c])) begin
          errors++;
          $display("FAIL zero known x%0d%0d: got %h want no X/Z", r + 1, c + 1, xo[r][c]);
        end
      end
    end
  endtask

  task automatic test_random();
    int v;
    for (int t = 0; t < 8; t++) begin
      for (int r = 0; r < 4; r++) begin
        for (int c = 0; c < 4; c++) begin
          v = int'($urandom_range(0, 767)) - 384;
          if (r == c && t[0]) v += 256;
          h[r][c] = v[15:0];
          v = (r == c) ? int'($urandom_range(0, 255)) : int'($urandom_range(0, 63)) - 32;
          n[r][c] = v[15:0];
        end
        v = int'($urandom_range(0, 1023)) - 512;
        y[r][0] = v[15:0];
        v = int'($urandom_range(0, 1023)) - 512;
        y[r][1] = v[15:0];
      end
      run_solve("random", 1'b0, 0);
    end
  endtask

  initial begin
    test_reset();
    test_identity();
    test_scaled();
    test_regularised();
    test_mixed();
    test_mid_reset();
    test_zero();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
